// File: rtl/pc_call_stack_pkg.sv
// Shared action encoding and priority decode for the program counter with return-address stack.
package pc_call_stack_pkg;

  localparam logic [2:0] ACT_HOLD = 3'd0;
  localparam logic [2:0] ACT_INC  = 3'd1;
  localparam logic [2:0] ACT_JUMP = 3'd2;
  localparam logic [2:0] ACT_CALL = 3'd3;
  localparam logic [2:0] ACT_RET  = 3'd4;
  localparam logic [2:0] ACT_OVF  = 3'd5;
  localparam logic [2:0] ACT_UDF  = 3'd6;

  // One action per cycle: jump > call > ret > increment; stall overrides everything.
  function automatic logic [2:0] decode_action(input logic enable, input logic jump,
                                               input logic call, input logic ret,
                                               input logic full, input logic empty);
    logic [2:0] act;
    act = ACT_INC;
    if (!enable)    act = ACT_HOLD;
    else if (jump)  act = ACT_JUMP;
    else if (call)  act = full  ? ACT_OVF : ACT_CALL;
    else if (ret)   act = empty ? ACT_UDF : ACT_RET;
    return act;
  endfunction

endpackage

// File: rtl/ras_lifo.sv
// Return-address LIFO: storage array plus level counter; contents are not reset.
module ras_lifo #(
  parameter int AW    = 12,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH+1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  din,
  output logic [AW-1:0]  top,
  output logic [SPW-1:0] level,
  output logic           full,
  output logic           empty
);
  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] level_q, level_d;
  logic [IW-1:0]  wr_idx, rd_idx;

  assign full   = (level_q == SPW'(DEPTH));
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign wr_idx = IW'(level_q);
  assign rd_idx = IW'(level_q - SPW'(1));
  assign top    = mem_q[rd_idx];

  always_comb begin
    level_d = level_q;
    if (push && !full)      level_d = level_q + SPW'(1);
    else if (pop && !empty) level_d = level_q - SPW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= '0;
    else       level_q <= level_d;
  end

  // Storage has no reset; a pushed word is readable as top on the following cycle.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with jump, call/return via ras_lifo, and sticky overflow/underflow flags.
module pc_call_stack
  import pc_call_stack_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH+1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           jump,
  input  logic           call,
  input  logic           ret,
  input  logic [AW-1:0]  target,
  input  logic           clear_err,
  output logic [AW-1:0]  pc,
  output logic [SPW-1:0] level,
  output logic           stack_full,
  output logic           stack_empty,
  output logic           overflow,
  output logic           underflow
);
  logic [AW-1:0] pc_q, pc_d, pc_inc, stk_top;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic [2:0]    action;
  logic          push, pop;

  assign action = decode_action(enable, jump, call, ret, stack_full, stack_empty);
  assign push   = (action == ACT_CALL);
  assign pop    = (action == ACT_RET);
  assign pc_inc = pc_q + AW'(1);

  ras_lifo #(.AW(AW), .DEPTH(DEPTH), .SPW(SPW)) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .level (level),
    .full  (stack_full),
    .empty (stack_empty)
  );

  always_comb begin
    pc_d = pc_q;
    case (action)
      ACT_INC:  pc_d = pc_inc;
      ACT_JUMP: pc_d = target;
      ACT_CALL: pc_d = target;
      ACT_RET:  pc_d = stk_top;
      default:  pc_d = pc_q;
    endcase
  end

  // A new error in the same cycle as clear_err leaves the flag set.
  always_comb begin
    overflow_d  = (clear_err ? 1'b0 : overflow_q)  | (action == ACT_OVF);
    underflow_d = (clear_err ? 1'b0 : underflow_q) | (action == ACT_UDF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign pc        = pc_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: directed scenarios with literal checks plus random traffic against a queue model.
module tb_pc_call_stack;
  localparam int AW     = 12;
  localparam int DEPTH  = 4;
  localparam int SPW    = $clog2(DEPTH+1);
  localparam int PC_MOD = 1 << AW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0, clear_err = 1'b0;
  logic [AW-1:0]  target = '0;
  logic [AW-1:0]  pc;
  logic [SPW-1:0] level;
  logic           stack_full, stack_empty, overflow, underflow;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Reference model
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_udf;

  always #5 clk = ~clk;

  pc_call_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .jump       (jump),
    .call       (call),
    .ret        (ret),
    .target     (target),
    .clear_err  (clear_err),
    .pc         (pc),
    .level      (level),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (clear_err) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (enable) begin
        if (jump) begin
          m_pc = int'(target);
        end else if (call) begin
          if (m_stk.size() == DEPTH) m_ovf = 1'b1;
          else begin
            m_stk.push_back((m_pc + 1) % PC_MOD);
            m_pc = int'(target);
          end
        end else if (ret) begin
          if (m_stk.size() == 0) m_udf = 1'b1;
          else m_pc = m_stk.pop_back();
        end else begin
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("model_pc",    int'(pc),          m_pc);
      check("model_level", int'(level),       m_stk.size());
      check("model_full",  int'(stack_full),  int'(m_stk.size() == DEPTH));
      check("model_empty", int'(stack_empty), int'(m_stk.size() == 0));
      check("model_ovf",   int'(overflow),    int'(m_ovf));
      check("model_udf",   int'(underflow),   int'(m_udf));
    end
  end

  task automatic step(input logic en, input logic j, input logic c, input logic r,
                      input logic [AW-1:0] tgt, input logic clr);
    @(negedge clk);
    enable = en; jump = j; call = c; ret = r; target = tgt; clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #12 reset = 1'b0;
    cmp_en = 1'b1;
    check("reset_pc", int'(pc), 0);
    check("reset_level", int'(level), 0);
    check("reset_empty", int'(stack_empty), 1);

    // Free-running increment
    for (int i = 1; i <= 5; i++) begin
      idle();
      check("inc_pc", int'(pc), i);
    end
    check("inc_level", int'(level), 0);

    // Single call/return
    step(1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 12'h200, 1'b0);
    check("call_pc", int'(pc), 'h200);
    check("call_level", int'(level), 1);
    for (int i = 1; i <= 3; i++) begin
      idle();
      check("sub_pc", int'(pc), 'h200 + i);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    check("ret_pc", int'(pc), 'h011);
    check("ret_level", int'(level), 0);

    // Nested calls to full, overflow, unwind, underflow
    step(1'b1, 1'b1, 1'b0, 1'b0, 12'h050, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 12'(12'h100 + 16 * i), 1'b0);
    check("nest_full", int'(stack_full), 1);
    check("nest_pc", int'(pc), 'h130);
    step(1'b1, 1'b0, 1'b1, 1'b0, 12'h300, 1'b0);
    check("ovf_pc", int'(pc), 'h130);
    check("ovf_flag", int'(overflow), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0); check("unwind1", int'(pc), 'h121);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0); check("unwind2", int'(pc), 'h111);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0); check("unwind3", int'(pc), 'h101);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0); check("unwind4", int'(pc), 'h051);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    check("udf_pc", int'(pc), 'h051);
    check("udf_flag", int'(underflow), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b1);
    check("clr_vs_set_udf", int'(underflow), 1);
    check("clr_vs_set_ovf", int'(overflow), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("clr_udf", int'(underflow), 0);

    // Priority
    step(1'b1, 1'b1, 1'b1, 1'b1, 12'h0AA, 1'b0);
    check("prio_jump_pc", int'(pc), 'h0AA);
    check("prio_jump_level", int'(level), 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 12'h0C0, 1'b0);
    check("prio_call_pc", int'(pc), 'h0C0);
    check("prio_call_level", int'(level), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    check("prio_ret_pc", int'(pc), 'h0AB);

    // Wrap
    step(1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b0);
    idle();
    check("wrap_pc", int'(pc), 0);
    check("wrap_no_err", int'(overflow | underflow), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 12'h010, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    check("wrap_push_pc", int'(pc), 0);

    // Stall with a pending call
    step(1'b1, 1'b0, 1'b1, 1'b0, 12'h222, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 12'h333, 1'b0);
      check("stall_pc", int'(pc), 'h222);
      check("stall_level", int'(level), 1);
    end

    // Async reset mid-cycle after two pushes
    step(1'b1, 1'b0, 1'b1, 1'b0, 12'h400, 1'b0);
    check("pre_rst_level", int'(level), 2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", int'(pc), 0);
    check("async_rst_level", int'(level), 0);
    check("async_rst_empty", int'(stack_empty), 1);
    #3 reset = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] t;
      t = (($urandom_range(0, 9) == 0)) ? 12'hFFE : AW'($urandom_range(0, PC_MOD - 1));
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           t, ($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised program counter for the processor front end.
- Adds synchronous jump, subroutine call and return through an internal return-address stack (LIFO).
- Drives the combinational program ROM address.
- Adds full/empty status and sticky overflow/underflow error flags, which a plain load/increment counter lacks.

Parameters:
- AW, 12, program address width in bits; pc wraps modulo 2^AW.
- DEPTH, 4, return-address stack entries (≥2).
- SPW, $clog2(DEPTH+1), width of the stack-level output (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears pc, stack level and error flags.
- enable  input  1  advance permission; 0 = stall (pc and stack frozen, all commands ignored).
- jump  input  1  load pc with target.
- call  input  1  push return address, load pc with target.
- ret  input  1  pop top of stack into pc.
- target  input  AW  jump/call destination.
- clear_err  input  1  synchronous clear of both sticky error flags.
- pc  output  AW  current program address (registered).
- level  output  SPW  number of valid stack entries, 0..DEPTH.
- stack_full  output  1  level == DEPTH (combinational from level).
- stack_empty  output  1  level == 0 (combinational from level).
- overflow  output  1  sticky: call attempted while full.
- underflow  output  1  sticky: ret attempted while empty.

Behaviour:
- Reset (async, any time, including mid-sequence): pc=0, level=0, overflow=0, underflow=0. Stack RAM contents are not cleared and are don't-care.
- All other updates occur on the rising clk edge.
- enable=0: hold pc, level and stack. Error flags still honour clear_err.
- enable=1: exactly one action per cycle, by priority jump > call > ret > increment. Lower-priority requests in the same cycle are dropped; they are not queued.
- jump: pc<=target; stack untouched.
- call, not full: stack[level]<=(pc+1) mod 2^AW; level<=level+1; pc<=target.
- call, full: no push; pc unchanged; overflow<=1.
- ret, not empty: pc<=stack[level-1]; level<=level-1.
- ret, empty: pc unchanged; underflow<=1.
- No command: pc<=pc+1, wrapping 2^AW-1 -> 0 with no flag.
- Latency: new pc is visible the cycle after the command edge. A ret issued directly after a call returns the address pushed by that call (the write is visible next cycle).
- clear_err and a new error in the same cycle: the set wins.
- Error flags never change pc or stack beyond the rules above.
- Interface timing: ROM reads pc combinationally. Commands are sampled registered, with no async load path.

Decomposition:
- Package pc_call_stack_pkg: action encoding constants ACT_HOLD, ACT_INC, ACT_JUMP, ACT_CALL, ACT_RET, ACT_OVF, ACT_UDF (3-bit localparams); a function computing the action from enable/jump/call/ret/full/empty.
- Sub-module ras_lifo: parameters AW and DEPTH; push, pop, din; outputs top, level, full, empty. Holds the stack array and level counter. pc_call_stack owns pc, the priority decode and the error flags.

Test Plan:
- Reset then enable=1 with no commands for 5 cycles -> pc 0,1,2,3,4,5; level=0, stack_empty=1.
- At pc=0x010, call with target=0x200; 3 increments; ret -> pc 0x200,0x201,0x202,0x203 then 0x011; level goes 1 then 0.
- Nested calls at AW=12, DEPTH=4: 4 calls fill the stack (stack_full=1). A 5th call with target=0x300 leaves pc unchanged and sets overflow=1. 4 rets unwind in LIFO order. A 5th ret sets underflow=1 with pc held. clear_err -> both flags 0.
- jump+call+ret asserted together with target=0x0AA -> pc=0x0AA, level unchanged. call+ret together -> call executes only.
- pc=0xFFF, no command -> pc=0x000, no error. call at pc=0xFFF pushes 0x000.
- enable=0 during a pending call -> pc/level frozen. Async reset asserted mid-cycle after 2 pushes -> pc=0 and level=0 immediately, before the next clk edge.
